// File: rtl/uart_loop_tester.sv
// UART loopback tester: sends an incrementing byte stream and counts echo mismatches and timeouts.
// Define LOOP_TESTER_STOP_ON_ERR_EN to end a run at the first mismatch or timeout.
module uart_loop_tester #(
   parameter int unsigned NUM_BYTES      = 256,
   parameter int unsigned TIMEOUT_CYCLES = 600_000,
   parameter logic [7:0]  SEED           = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [7:0]  tx_data,
   output logic        uart_wr,
   input  logic        tx_busy,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        uart_rd,
   output logic        running,
   output logic        done,
   output logic        pass,
   output logic [15:0] err_count,
   output logic [15:0] timeout_count
);

   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

`ifdef LOOP_TESTER_STOP_ON_ERR_EN
   localparam bit STOP_ON_ERR = 1'b1;
`else
   localparam bit STOP_ON_ERR = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_ECHO,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [15:0]     idx_q, idx_d;
   logic [7:0]      exp_q, exp_d;
   logic [15:0]     err_q, err_d;
   logic [15:0]     tmo_q, tmo_d;
   logic [TW-1:0]   wait_q, wait_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            wr_q, wr_d;
   logic            rd_q, rd_d;
   logic            rd_block_q, rd_block_d;

   logic            echo_ok;
   logic            advance;
   logic            fail;

   // rx_valid may still reflect the byte just read while the strobe is out and for one cycle after
   assign echo_ok = rx_valid && !rd_q && !rd_block_q;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      exp_d      = exp_q;
      err_d      = err_q;
      tmo_d      = tmo_q;
      wait_d     = wait_q;
      tx_data_d  = tx_data_q;
      wr_d       = 1'b0;
      rd_d       = 1'b0;
      rd_block_d = rd_q;
      advance    = 1'b0;
      fail       = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (echo_ok) begin
               rd_d = 1'b1;
            end
            if (start) begin
               state_d = SEND;
               idx_d   = '0;
               exp_d   = SEED;
               err_d   = '0;
               tmo_d   = '0;
            end
         end
         SEND: begin
            if (!tx_busy) begin
               tx_data_d = exp_q;
               wr_d      = 1'b1;
               wait_d    = '0;
               state_d   = WAIT_ECHO;
            end
         end
         WAIT_ECHO: begin
            if (echo_ok) begin
               rd_d    = 1'b1;
               advance = 1'b1;
               if (rx_data != exp_q) begin
                  fail = 1'b1;
                  if (err_q != '1) begin
                     err_d = err_q + 16'd1;
                  end
               end
            end else if (wait_q == TW'(TIMEOUT_CYCLES - 1)) begin
               advance = 1'b1;
               fail    = 1'b1;
               if (tmo_q != '1) begin
                  tmo_d = tmo_q + 16'd1;
               end
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (advance) begin
         exp_d = exp_q + 8'd1;
         idx_d = idx_q + 16'd1;
         if (({1'b0, idx_q} + 17'd1) == 17'(NUM_BYTES)) begin
            state_d = DONE;
         end else begin
            state_d = SEND;
         end
         if (STOP_ON_ERR && fail) begin
            state_d = DONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         exp_q      <= '0;
         err_q      <= '0;
         tmo_q      <= '0;
         wait_q     <= '0;
         tx_data_q  <= '0;
         wr_q       <= 1'b0;
         rd_q       <= 1'b0;
         rd_block_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         exp_q      <= exp_d;
         err_q      <= err_d;
         tmo_q      <= tmo_d;
         wait_q     <= wait_d;
         tx_data_q  <= tx_data_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         rd_block_q <= rd_block_d;
      end
   end

   assign tx_data       = tx_data_q;
   assign uart_wr       = wr_q;
   assign uart_rd       = rd_q;
   assign running       = (state_q == SEND) || (state_q == WAIT_ECHO);
   assign done          = (state_q == DONE);
   assign pass          = (state_q == DONE) && (err_q == '0) && (tmo_q == '0);
   assign err_count     = err_q;
   assign timeout_count = tmo_q;

endmodule

// File: tb/tb_uart_loop_tester.sv
// Bench for uart_loop_tester: emulated loopback UART with per-byte echo faults and a
// cycle-level model of sent bytes, error and timeout counts.
module tb_uart_loop_tester;

   localparam int         NB       = 4;
   localparam int         TMO      = 100;
   localparam logic [7:0] SD       = 8'hFE;
   localparam int         ECHO_DLY = 3;
   localparam int         OK       = 0;
   localparam int         CORRUPT  = 1;
   localparam int         DROP     = 2;
`ifdef LOOP_TESTER_STOP_ON_ERR_EN
   localparam bit         STOP     = 1'b1;
`else
   localparam bit         STOP     = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  tx_data;
   logic        uart_wr;
   logic        tx_busy;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        uart_rd;
   logic        running;
   logic        done;
   logic        pass;
   logic [15:0] err_count;
   logic [15:0] timeout_count;

   always #5 clk = ~clk;

   uart_loop_tester #(
      .NUM_BYTES      (NB),
      .TIMEOUT_CYCLES (TMO),
      .SEED           (SD)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .tx_data       (tx_data),
      .uart_wr       (uart_wr),
      .tx_busy       (tx_busy),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .uart_rd       (uart_rd),
      .running       (running),
      .done          (done),
      .pass          (pass),
      .err_count     (err_count),
      .timeout_count (timeout_count)
   );

   // emulated UART state
   int         mode [256];
   bit         force_busy;
   bit         rx_full, rx_consumed, rx_stray;
   int         rx_idx;
   int         drain_cnt, echo_cnt, echo_idx;
   logic [7:0] echo_byte, d8;
   int         inject_req, inject_seen;

   // model / scoreboard state
   int         checks, passes;
   int         cyc, sent, model_err, n_rd, n_tmo;
   int         clr_req, clr_seen;
   int         tmo_due [$];
   logic [7:0] sent_bytes [NB+4];
   int         wr_cyc [NB+4];
   bit         prev_wr, prev_rd;
   logic [7:0] eb;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic void run_expect(output int s, output int e, output int t);
      s = 0; e = 0; t = 0;
      for (int i = 0; i < NB; i++) begin
         s++;
         if (mode[i] == CORRUPT) e++;
         else if (mode[i] == DROP) t++;
         if (STOP && (e + t) != 0) break;
      end
   endfunction

   // loopback UART: echoes each written byte after ECHO_DLY cycles; rx_valid drops two cycles after the read strobe
   initial begin
      rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
      rx_full = 1'b0; rx_consumed = 1'b0; rx_stray = 1'b0; rx_idx = 0;
      drain_cnt = 0; echo_cnt = 0; echo_idx = 0; echo_byte = 8'h00; inject_seen = 0;
      forever begin
         @(negedge clk);
         tx_busy = force_busy;
         if (reset) begin
            rx_full = 1'b0; rx_consumed = 1'b0; rx_valid = 1'b0;
            drain_cnt = 0; echo_cnt = 0;
         end else begin
            if (drain_cnt != 0) begin
               drain_cnt--;
               if (drain_cnt == 0) begin
                  rx_full = 1'b0; rx_consumed = 1'b0; rx_valid = 1'b0;
               end
            end
            if (uart_rd && rx_full && !rx_consumed) begin
               rx_consumed = 1'b1;
               drain_cnt = 2;
            end
            if (echo_cnt != 0) begin
               echo_cnt--;
               if (echo_cnt == 0) begin
                  rx_full = 1'b1; rx_consumed = 1'b0; rx_stray = 1'b0;
                  rx_idx = echo_idx; rx_data = echo_byte; rx_valid = 1'b1;
               end
            end
            if (inject_req != inject_seen && !rx_full) begin
               inject_seen = inject_req;
               rx_full = 1'b1; rx_consumed = 1'b0; rx_stray = 1'b1;
               rx_data = 8'h55; rx_valid = 1'b1;
            end
            if (uart_wr) begin
               d8 = tx_data - SD;
               echo_idx = int'(d8);
               if (mode[echo_idx] != DROP) begin
                  echo_cnt = ECHO_DLY;
                  echo_byte = (mode[echo_idx] == CORRUPT) ? (tx_data ^ 8'h80) : tx_data;
               end
            end
         end
      end
   end

   // per-cycle compare against the model
   initial begin
      cyc = 0; sent = 0; model_err = 0; n_rd = 0; clr_seen = 0;
      prev_wr = 1'b0; prev_rd = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (clr_req != clr_seen) begin
            clr_seen = clr_req;
            sent = 0; model_err = 0;
            tmo_due.delete();
         end
         if (uart_wr) begin
            eb = SD + 8'(sent);
            chk("wr_consecutive", 32'(prev_wr), 32'd0);
            chk("wr_while_busy", 32'(tx_busy), 32'd0);
            chk("wr_running", 32'(running), 32'd1);
            chk("wr_index_range", 32'(sent < NB), 32'd1);
            chk("tx_byte", 32'(tx_data), 32'(eb));
            if (sent < NB + 4) begin
               sent_bytes[sent] = tx_data;
               wr_cyc[sent] = cyc;
            end
            if (sent < 256 && mode[sent] == DROP) tmo_due.push_back(cyc + TMO);
            sent++;
         end
         if (uart_rd) begin
            chk("rd_consecutive", 32'(prev_rd), 32'd0);
            chk("rd_has_byte", 32'(rx_full && !rx_consumed), 32'd1);
            n_rd++;
            if (rx_full && !rx_consumed && !rx_stray) begin
               eb = SD + 8'(rx_idx);
               if (rx_data != eb) model_err++;
            end
         end
         n_tmo = 0;
         foreach (tmo_due[i]) if (tmo_due[i] <= cyc) n_tmo++;
         chk("err_count", 32'(err_count), model_err);
         chk("timeout_count", 32'(timeout_count), n_tmo);
         chk("running_done_exclusive", 32'(running & done), 32'd0);
         chk("pass_implies_done", 32'(pass & ~done), 32'd0);
         prev_wr = uart_wr;
         prev_rd = uart_rd;
      end
   end

   task automatic start_run();
      start = 1'b1;
      clr_req++;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("done_within_budget", 32'(done), 32'd1);
   endtask

   task automatic check_run_result();
      int es, ee, et;
      run_expect(es, ee, et);
      chk("bytes_sent", sent, es);
      chk("err_final", 32'(err_count), ee);
      chk("tmo_final", 32'(timeout_count), et);
      chk("pass_final", 32'(pass), 32'(ee == 0 && et == 0));
      chk("running_final", 32'(running), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
      chk({tag, "_uart_wr"}, 32'(uart_wr), 32'd0);
      chk({tag, "_uart_rd"}, 32'(uart_rd), 32'd0);
      chk({tag, "_running"}, 32'(running), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_pass"}, 32'(pass), 32'd0);
      chk({tag, "_err"}, 32'(err_count), 32'd0);
      chk({tag, "_tmo"}, 32'(timeout_count), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int rd0, n;
      reset = 1'b1; start = 1'b0; force_busy = 1'b0;
      checks = 0; passes = 0; clr_req = 0; inject_req = 0;
      foreach (mode[i]) mode[i] = OK;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");

      // ideal echo, start in the first cycle out of reset
      reset = 1'b0;
      @(negedge clk);
      start_run();
      chk("start_to_send", 32'(running), 32'd1);
      wait_done(2000);
      check_run_result();
      chk("ideal_byte0", 32'(sent_bytes[0]), 32'h0000_00FE);
      chk("ideal_byte1", 32'(sent_bytes[1]), 32'h0000_00FF);
      chk("ideal_byte2", 32'(sent_bytes[2]), 32'h0000_0000);
      chk("ideal_byte3", 32'(sent_bytes[3]), 32'h0000_0001);
      chk("ideal_pass", 32'(pass), 32'd1);

      // stray byte while DONE
      rd0 = n_rd;
      inject_req++;
      repeat (10) @(negedge clk);
      chk("stray_done_rd_pulses", n_rd - rd0, 32'd1);
      chk("stray_done_err", 32'(err_count), 32'd0);
      chk("stray_done_hold", 32'(done & pass), 32'd1);

      // third echo corrupted
      mode[2] = CORRUPT;
      start_run();
      wait_done(2000);
      check_run_result();
`ifdef LOOP_TESTER_STOP_ON_ERR_EN
      chk("corrupt_sent_lit", sent, 32'd3);
`else
      chk("corrupt_sent_lit", sent, 32'd4);
`endif
      chk("corrupt_err_lit", 32'(err_count), 32'd1);
      mode[2] = OK;

      // second echo missing
      mode[1] = DROP;
      @(negedge clk);
      start_run();
      wait_done(2000);
      check_run_result();
      chk("drop_tmo_lit", 32'(timeout_count), 32'd1);
`ifdef LOOP_TESTER_STOP_ON_ERR_EN
      chk("drop_sent_lit", sent, 32'd2);
`else
      chk("drop_gap_cycles", wr_cyc[2] - wr_cyc[1], 32'd101);
`endif
      mode[1] = OK;

      // transmitter busy for 50 cycles in SEND
      force_busy = 1'b1;
      @(negedge clk);
      start_run();
      repeat (50) @(negedge clk);
      chk("busy_no_wr", sent, 32'd0);
      chk("busy_running", 32'(running), 32'd1);
      force_busy = 1'b0;
      wait_done(2000);
      check_run_result();

      // start pulsed mid-run is ignored
      start_run();
      repeat (5) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(2000);
      check_run_result();

      // reset while waiting for an echo
      mode[0] = DROP;
      start_run();
      n = 0;
      while (sent == 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("abort_wr_seen", sent, 32'd1);
      repeat (5) @(negedge clk);
      chk("abort_in_wait", 32'(running), 32'd1);
      reset = 1'b1;
      clr_req++;
      @(negedge clk);
      check_reset_outputs("abort");
      reset = 1'b0;
      mode[0] = OK;
      @(negedge clk);

      // stray byte while IDLE
      rd0 = n_rd;
      inject_req++;
      repeat (10) @(negedge clk);
      chk("stray_idle_rd_pulses", n_rd - rd0, 32'd1);
      chk("stray_idle_err", 32'(err_count), 32'd0);

      start_run();
      wait_done(2000);
      check_run_result();
      chk("after_abort_pass", 32'(pass), 32'd1);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/uart_loop_tester.md
UART_LOOP_TESTER -- requirements
Module: uart_loop_tester

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 256, bytes sent per run (legal range 1..65535).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 600_000, echo wait limit in clk cycles (10 ms at 60 MHz).
REQ-003 SHALL have parameter SEED, default 8'h00, value of the first byte sent.
REQ-004 SHALL have port clk, input, 1 bit, sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit, single-cycle run request.
REQ-007 SHALL have port tx_data, output, 8 bits, byte to the uart transmitter.
REQ-008 SHALL have port uart_wr, output, 1 bit, one-cycle write strobe to the uart.
REQ-009 SHALL have port tx_busy, input, 1 bit, uart transmitter busy.
REQ-010 SHALL have port rx_data, input, 8 bits, received byte from the uart.
REQ-011 SHALL have port rx_valid, input, 1 bit, uart holds an unread byte.
REQ-012 SHALL have port uart_rd, output, 1 bit, one-cycle read strobe to the uart.
REQ-013 SHALL have port running, output, 1 bit, run in progress.
REQ-014 SHALL have port done, output, 1 bit, run finished; held until next start or reset.
REQ-015 SHALL have port pass, output, 1 bit, done with err_count==0 and timeout_count==0.
REQ-016 SHALL have ports err_count and timeout_count, outputs, 16 bits each, saturating at 16'hFFFF.

Function
REQ-017 States SHALL be IDLE, SEND, WAIT_ECHO, DONE.
REQ-018 IDLE or DONE, start=1: clear both counters, done, pass; set byte index 0 and expected=SEED; go to SEND next cycle.
REQ-019 start in SEND or WAIT_ECHO SHALL be ignored.
REQ-020 SEND, tx_busy=0: drive tx_data=expected, assert uart_wr exactly one cycle, load timeout counter 0, go to WAIT_ECHO.
REQ-021 SEND, tx_busy=1: hold in SEND with uart_wr=0.
REQ-022 WAIT_ECHO, rx_valid=1: assert uart_rd one cycle; increment err_count if rx_data!=expected; then advance byte.
REQ-023 rx_valid SHALL be ignored for the one cycle following any uart_rd pulse (strobe-to-valid-drop latency).
REQ-024 WAIT_ECHO, no rx_valid at cycle TIMEOUT_CYCLES-1: increment timeout_count, advance byte.
REQ-025 rx_valid and timeout in the same cycle: the echo wins; no timeout counted.
REQ-026 Advance byte: expected <= expected+1 mod 256 (8'hFF wraps to 8'h00); index+1; if index+1==NUM_BYTES go to DONE, else SEND.
REQ-027 DONE: done=1, running=0, pass per REQ-015, updated in the cycle DONE is entered.
REQ-028 IDLE/DONE, rx_valid=1 (stray byte): pulse uart_rd to drain it; counters unchanged.
REQ-029 uart_wr and uart_rd SHALL never be high for two consecutive cycles.
REQ-030 running SHALL be 1 exactly in SEND and WAIT_ECHO.

Reset
REQ-031 reset=1 SHALL force IDLE, uart_wr=0, uart_rd=0, tx_data=0, running=0, done=0, pass=0, both counters 0, index 0, regardless of state (mid-run abort).
REQ-032 First start SHALL be accepted in the cycle after reset deasserts.

Configuration
REQ-033 Macro LOOP_TESTER_STOP_ON_ERR_EN defined: first mismatch or timeout SHALL go directly to DONE with pass=0, remaining bytes unsent.
REQ-034 Macro undefined: run SHALL always complete all NUM_BYTES bytes, counting every failure.

Verification
REQ-035 Ideal echo model, NUM_BYTES=4, SEED=8'hFE: bytes FE,FF,00,01 sent -> done=1, pass=1, counters 0.
REQ-036 Echo corrupts 3rd byte (00->80), NUM_BYTES=4: macro off -> err_count=1, pass=0, 4 bytes sent; macro on -> DONE after 3rd byte, 3 bytes sent.
REQ-037 No echo on 2nd byte, TIMEOUT_CYCLES=100: timeout_count=1 after exactly 100 wait cycles, run continues (macro off).
REQ-038 tx_busy held high 50 cycles in SEND -> no uart_wr until busy drops, then a single 1-cycle pulse.
REQ-039 reset asserted in WAIT_ECHO -> next cycle all outputs at REQ-031 values; new start runs cleanly to pass=1.
REQ-040 Stray rx_valid in IDLE -> one uart_rd pulse, err_count=0; start pulsed during run -> no restart.
